mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle control unit and PC owner for the TSC CPU; sits directly upstream of the datapath.
- Sequences IF/ID/EX/MEM/WB per instruction.
- Drives every datapath control input: IRWrite, RegWrite, RegWriteSrc, RegDst, ALUOp, ALUSrcA, ALUSrcB.
- Supplies inst_addr/inst_seq_addr and handshakes with the shared memory bus.

Parameters:
WORD_SIZE, 16, datapath and PC width
RESET_PC, 16'h0000, PC value after reset

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
instruction  in  16  memory read data, latched into the internal IR copy on IRWrite
ALU_out_C  in  16  combinational ALU result from the datapath (branch target, JPR/JRL address)
ALU_Cmp  in  2  ALU compare result: 00 A==B, 01 A>B, 10 A<B
RF_addr  in  16  rs register value (JPR/JRL target)
inputReady  in  1  memory read data valid
ackOutput  in  1  memory write accepted
readM  out  1  memory read request
writeM  out  1  memory write request
IorD  out  1  memory address select: 0 = inst_addr, 1 = ALUOut
inst_addr  out  16  current PC
inst_seq_addr  out  16  PC+1
IRWrite  out  1  datapath IR load
RegWrite  out  1  register file write enable
RegWriteSrc  out  2  0 ALU, 1 MEM, 2 PC
RegDst  out  2  0 rd, 1 rt, 2 $2
ALUOp  out  4  ALU function code
ALUSrcA  out  2  0 rs, 1 PC, 2 PC+1
ALUSrcB  out  2  0 rt, 1 const 1, 2 sign-extended imm, 3 zero
output_active  out  1  one-cycle WWD strobe
is_halted  out  1  HLT reached
num_inst  out  16  retired instruction count

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset values: state=INIT, PC=RESET_PC, num_inst=0, is_halted=0, IR=0. All strobes (readM, writeM, IRWrite, RegWrite, output_active) are 0. All select outputs are 0.
- Mid-operation reset: readM/writeM drop immediately and any pending access is abandoned.
- Output style: Moore outputs decoded from state and IR.
- States: INIT, IF, ID, EX, MEM, WB, HALT.
- INIT: go to IF on the next clock.
- IF:
  - readM=1, IorD=0.
  - On inputReady: IRWrite=1 in that cycle, then go to ID.
  - Otherwise hold IF with readM asserted.
- ID:
  - ALUSrcA=2, ALUSrcB=2, ALUOp=ADD, so the datapath latches the branch target into ALUOut.
  - Decode as follows:
    - JMP/JAL: PC<={PC[15:12],IR[11:0]}. JAL also does RegWrite=1, RegDst=2, RegWriteSrc=2 (writes the old PC+1). Instruction completes.
    - JPR/JRL: PC<=RF_addr. JRL also writes $2 as for JAL. Instruction completes.
    - HLT: go to HALT.
    - WWD: output_active=1 for this cycle. Instruction completes.
    - All others: go to EX.
- EX:
  - R-type ALU ops: ALUSrcA=0, ALUSrcB=0, ALUOp=func[3:0]. Go to WB.
  - ADI/ORI/LHI: ALUSrcB=2 and the matching ALUOp. Go to WB.
  - LWD/SWD: ALUSrcA=0, ALUSrcB=2, ALUOp=ADD. Go to MEM.
  - BNE/BEQ: ALUSrcB=0. BGZ/BLZ: ALUSrcB=3.
    - Taken conditions: BNE Cmp!=00, BEQ Cmp==00, BGZ Cmp==01, BLZ Cmp==10.
    - Taken: PC<=ALUOut (latched in ID). Not taken: PC<=PC+1.
    - Instruction completes.
- MEM:
  - IorD=1. LWD holds readM until inputReady, then goes to WB. SWD holds writeM until ackOutput, then completes.
  - Request stays asserted while waiting.
- WB:
  - RegWrite=1 for exactly one cycle. RegDst=0 for R-type, 1 for I-type. RegWriteSrc=1 for LWD, 0 otherwise.
  - Instruction completes.
- Completion: PC<=PC+1 unless a jump or taken branch updated it. num_inst+=1 (wraps at 16'hFFFF→0). Return to IF.
- HALT: absorbing until reset. is_halted=1, num_inst frozen, no memory requests.
- Illegal opcode/func: treated as a NOP that completes in ID.

Decomposition:
- Shared package (opcodes.v):
  - opcode/func encodings: opcodes BNE0 BEQ1 BGZ2 BLZ3 ADI4 ORI5 LHI6 LWD7 SWD8 JMP9 JAL10 R15; funcs ADD0..SHR7 JPR25 JRL26 WWD28 HLT29.
  - Field index macros.
  - RegDst_*, RegWriteSrc_*, ALUSrcA_*, ALUSrcB_* and ALUOp constants.
  - State encoding.
- One natural sub-module: mc_decode, a combinational IR→instruction-class/ALUOp decoder.

Test Plan:
- Reset released with memory returning ADI $1,$0,5 after 2 wait cycles → readM high for 3 cycles, IRWrite pulses once; EX then WB with RegWrite=1, RegDst=1; PC 0→1; num_inst=1.
- BEQ $0,$0,+3 at PC=4 with ALU_Cmp=00 in EX → PC=8. Same instruction with ALU_Cmp=01 → PC=5.
- JAL 0x123 at PC=16'h2010 → PC=16'h2123; RegWrite with RegDst=2, RegWriteSrc=2 in ID.
- SWD with ackOutput delayed 4 cycles → writeM held 4 cycles with IorD=1; no RegWrite; PC+1.
- HLT → is_halted=1, readM stays 0 for 20 cycles, num_inst unchanged.
- reset_n low during LWD MEM wait → readM drops asynchronously; after release PC=0, num_inst=0, state INIT→IF.

Source files
------------

// File: rtl/mc_control_pkg.sv
// Shared definitions for the TSC multicycle control unit.
// Contents: instruction field positions, opcode/func encodings, ALU function
// codes, datapath select encodings, FSM state encoding, and the decoded
// instruction record passed from mc_decode to mc_control.
package mc_control_pkg;

  // Instruction field positions (16-bit TSC format).
  localparam int OP_HI   = 15;
  localparam int OP_LO   = 12;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;
  localparam int TGT_HI  = 11;
  localparam int TGT_LO  = 0;

  // Opcodes.
  localparam logic [3:0] OP_BNE = 4'd0;
  localparam logic [3:0] OP_BEQ = 4'd1;
  localparam logic [3:0] OP_BGZ = 4'd2;
  localparam logic [3:0] OP_BLZ = 4'd3;
  localparam logic [3:0] OP_ADI = 4'd4;
  localparam logic [3:0] OP_ORI = 4'd5;
  localparam logic [3:0] OP_LHI = 4'd6;
  localparam logic [3:0] OP_LWD = 4'd7;
  localparam logic [3:0] OP_SWD = 4'd8;
  localparam logic [3:0] OP_JMP = 4'd9;
  localparam logic [3:0] OP_JAL = 4'd10;
  localparam logic [3:0] OP_R   = 4'd15;

  // R-type function codes.
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU function codes; 0..7 match the R-type func field directly.
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_NOT = 4'd4;
  localparam logic [3:0] ALU_TCP = 4'd5;
  localparam logic [3:0] ALU_SHL = 4'd6;
  localparam logic [3:0] ALU_SHR = 4'd7;
  localparam logic [3:0] ALU_LHI = 4'd8;

  // Datapath select encodings.
  localparam logic [1:0] REGDST_RD   = 2'd0;
  localparam logic [1:0] REGDST_RT   = 2'd1;
  localparam logic [1:0] REGDST_R2   = 2'd2;
  localparam logic [1:0] RWSRC_ALU   = 2'd0;
  localparam logic [1:0] RWSRC_MEM   = 2'd1;
  localparam logic [1:0] RWSRC_PC    = 2'd2;
  localparam logic [1:0] SRCA_RS     = 2'd0;
  localparam logic [1:0] SRCA_PC     = 2'd1;
  localparam logic [1:0] SRCA_PC1    = 2'd2;
  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_ONE    = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_ZERO   = 2'd3;

  typedef enum logic [2:0] {
    S_INIT, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_NOP,       // illegal encodings complete in ID with no effect
    C_ALU_R,
    C_ALU_I,     // ADI / ORI / LHI
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,      // JMP / JAL
    C_JUMP_REG,  // JPR / JRL
    C_WWD,
    C_HLT
  } iclass_e;

  typedef struct packed {
    iclass_e    iclass;
    logic [3:0] alu_op;     // ALU function used in EX/WB
    logic [1:0] alu_src_b;  // ALUSrcB used in EX/WB
    logic       link;       // JAL/JRL: write PC+1 into $2
    logic       br_taken;   // branch condition holds for current ALU_Cmp
  } decode_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder for mc_control.
// Ports:
//   opcode   in  IR[15:12]
//   func     in  IR[5:0]
//   cmp      in  ALU compare result (00 eq, 01 gt, 10 lt)
//   dec      out instruction class, EX ALU controls, link flag, branch-taken
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [5:0] func,
  input  logic [1:0] cmp,
  output decode_t    dec
);

  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves
    // dec unassigned, which would otherwise infer a latch.
    dec = '{iclass: C_NOP, alu_op: ALU_ADD, alu_src_b: SRCB_RT,
            link: 1'b0, br_taken: 1'b0};
    case (opcode)
      OP_BNE: begin
        dec.iclass   = C_BRANCH;
        dec.alu_op   = ALU_SUB;
        dec.br_taken = (cmp != 2'b00);
      end
      OP_BEQ: begin
        dec.iclass   = C_BRANCH;
        dec.alu_op   = ALU_SUB;
        dec.br_taken = (cmp == 2'b00);
      end
      OP_BGZ: begin
        dec.iclass    = C_BRANCH;
        dec.alu_op    = ALU_SUB;
        dec.alu_src_b = SRCB_ZERO;
        dec.br_taken  = (cmp == 2'b01);
      end
      OP_BLZ: begin
        dec.iclass    = C_BRANCH;
        dec.alu_op    = ALU_SUB;
        dec.alu_src_b = SRCB_ZERO;
        dec.br_taken  = (cmp == 2'b10);
      end
      OP_ADI: begin
        dec.iclass    = C_ALU_I;
        dec.alu_src_b = SRCB_IMM;
      end
      OP_ORI: begin
        dec.iclass    = C_ALU_I;
        dec.alu_op    = ALU_ORR;
        dec.alu_src_b = SRCB_IMM;
      end
      OP_LHI: begin
        dec.iclass    = C_ALU_I;
        dec.alu_op    = ALU_LHI;
        dec.alu_src_b = SRCB_IMM;
      end
      OP_LWD: begin
        dec.iclass    = C_LOAD;
        dec.alu_src_b = SRCB_IMM;
      end
      OP_SWD: begin
        dec.iclass    = C_STORE;
        dec.alu_src_b = SRCB_IMM;
      end
      OP_JMP: dec.iclass = C_JUMP;
      OP_JAL: begin
        dec.iclass = C_JUMP;
        dec.link   = 1'b1;
      end
      OP_R: begin
        if (func <= FN_SHR) begin
          dec.iclass = C_ALU_R;
          dec.alu_op = func[3:0];
        end else begin
          case (func)
            FN_JPR: dec.iclass = C_JUMP_REG;
            FN_JRL: begin
              dec.iclass = C_JUMP_REG;
              dec.link   = 1'b1;
            end
            FN_WWD: dec.iclass = C_WWD;
            FN_HLT: dec.iclass = C_HLT;
            default: dec.iclass = C_NOP;
          endcase
        end
      end
      default: dec.iclass = C_NOP;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle control unit and PC owner for the TSC CPU.
// Sequences IF/ID/EX/MEM/WB, drives every datapath control input and
// handshakes with the shared memory bus.
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   instruction             memory read data, captured into IR in IF
//   ALU_out_C, ALU_Cmp      datapath ALU result / compare flags
//   RF_addr                 rs value for JPR/JRL
//   inputReady, ackOutput   memory read-valid / write-accepted
//   readM, writeM, IorD     memory request strobes and address select
//   inst_addr, inst_seq_addr  PC and PC+1
//   IRWrite, RegWrite, RegWriteSrc, RegDst, ALUOp, ALUSrcA, ALUSrcB
//                           datapath controls
//   output_active           one-cycle WWD strobe
//   is_halted, num_inst     halt flag and retired-instruction count
module mc_control
  import mc_control_pkg::*;
#(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [15:0]          instruction,
  input  logic [WORD_SIZE-1:0] ALU_out_C,
  input  logic [1:0]           ALU_Cmp,
  input  logic [WORD_SIZE-1:0] RF_addr,
  input  logic                 inputReady,
  input  logic                 ackOutput,
  output logic                 readM,
  output logic                 writeM,
  output logic                 IorD,
  output logic [WORD_SIZE-1:0] inst_addr,
  output logic [WORD_SIZE-1:0] inst_seq_addr,
  output logic                 IRWrite,
  output logic                 RegWrite,
  output logic [1:0]           RegWriteSrc,
  output logic [1:0]           RegDst,
  output logic [3:0]           ALUOp,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 output_active,
  output logic                 is_halted,
  output logic [15:0]          num_inst
);

  state_e               state;
  logic [15:0]          ir;
  logic [WORD_SIZE-1:0] pc;
  logic [WORD_SIZE-1:0] alu_out_q;   // branch target captured in ID
  logic [WORD_SIZE-1:0] pc_seq;
  logic [WORD_SIZE-1:0] pc_next;
  logic                 retire;
  decode_t              dec;

  mc_decode u_decode (
    .opcode (ir[OP_HI:OP_LO]),
    .func   (ir[FUNC_HI:FUNC_LO]),
    .cmp    (ALU_Cmp),
    .dec    (dec)
  );

  assign pc_seq        = pc + WORD_SIZE'(1);
  assign inst_addr     = pc;
  assign inst_seq_addr = pc_seq;

  // Instruction completion and the PC it leaves behind.
  always_comb begin
    retire  = 1'b0;
    pc_next = pc_seq;
    case (state)
      S_ID: begin
        case (dec.iclass)
          C_JUMP: begin
            retire  = 1'b1;
            pc_next = {pc[WORD_SIZE-1:TGT_HI+1], ir[TGT_HI:TGT_LO]};
          end
          C_JUMP_REG: begin
            retire  = 1'b1;
            pc_next = RF_addr;
          end
          C_NOP, C_WWD: retire = 1'b1;
          default: ;
        endcase
      end
      S_EX: begin
        if (dec.iclass == C_BRANCH) begin
          retire = 1'b1;
          if (dec.br_taken) pc_next = alu_out_q;
        end
      end
      S_MEM: retire = (dec.iclass == C_STORE) && ackOutput;
      S_WB:  retire = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_INIT;
      pc        <= RESET_PC;
      ir        <= '0;
      alu_out_q <= '0;
      num_inst  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (state == S_ID) alu_out_q <= ALU_out_C;
      if (retire) begin
        pc       <= pc_next;
        num_inst <= num_inst + 16'd1;
        state    <= S_IF;
      end else begin
        case (state)
          S_INIT: state <= S_IF;
          S_IF: begin
            if (inputReady) begin
              ir    <= instruction;
              state <= S_ID;
            end
          end
          S_ID:  state <= (dec.iclass == C_HLT) ? S_HALT : S_EX;
          S_EX:  state <= (dec.iclass == C_LOAD || dec.iclass == C_STORE)
                          ? S_MEM : S_WB;
          S_MEM: if (dec.iclass == C_LOAD && inputReady) state <= S_WB;
          S_HALT: state <= S_HALT;
          default: state <= S_INIT;
        endcase
      end
    end
  end

  // Outputs decode from state and IR only, so asserting reset_n low clears
  // every request and strobe immediately through the async state reset.
  always_comb begin
    readM         = 1'b0;
    writeM        = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegWrite      = 1'b0;
    RegWriteSrc   = RWSRC_ALU;
    RegDst        = REGDST_RD;
    ALUOp         = ALU_ADD;
    ALUSrcA       = SRCA_RS;
    ALUSrcB       = SRCB_RT;
    output_active = 1'b0;
    is_halted     = 1'b0;
    case (state)
      S_IF: begin
        readM   = 1'b1;
        IRWrite = inputReady;
      end
      S_ID: begin
        // Precompute PC+1+imm so the branch target is ready for EX.
        ALUSrcA = SRCA_PC1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
        if ((dec.iclass == C_JUMP || dec.iclass == C_JUMP_REG) && dec.link) begin
          RegWrite    = 1'b1;
          RegDst      = REGDST_R2;
          RegWriteSrc = RWSRC_PC;
        end
        output_active = (dec.iclass == C_WWD);
      end
      S_EX: begin
        ALUSrcA = SRCA_RS;
        ALUSrcB = dec.alu_src_b;
        ALUOp   = dec.alu_op;
      end
      S_MEM: begin
        IorD   = 1'b1;
        readM  = (dec.iclass == C_LOAD);
        writeM = (dec.iclass == C_STORE);
      end
      S_WB: begin
        RegWrite    = 1'b1;
        RegDst      = (dec.iclass == C_ALU_R) ? REGDST_RD : REGDST_RT;
        RegWriteSrc = (dec.iclass == C_LOAD) ? RWSRC_MEM : RWSRC_ALU;
        // Keep the ALU steered as in EX so its result is stable for writeback.
        if (dec.iclass == C_ALU_R || dec.iclass == C_ALU_I) begin
          ALUSrcB = dec.alu_src_b;
          ALUOp   = dec.alu_op;
        end
      end
      S_HALT: is_halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed testbench for mc_control: the bench plays the memory and the
// datapath, stepping one instruction at a time and comparing control
// outputs against hand-computed values.
module tb_mc_control;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] instruction;
  logic [15:0] ALU_out_C;
  logic [1:0]  ALU_Cmp;
  logic [15:0] RF_addr;
  logic        inputReady;
  logic        ackOutput;
  logic        readM, writeM, IorD, IRWrite, RegWrite;
  logic [15:0] inst_addr, inst_seq_addr, num_inst;
  logic [1:0]  RegWriteSrc, RegDst, ALUSrcA, ALUSrcB;
  logic [3:0]  ALUOp;
  logic        output_active, is_halted;

  int tests_run = 0;
  int tests_failed = 0;

  mc_control #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instruction   (instruction),
    .ALU_out_C     (ALU_out_C),
    .ALU_Cmp       (ALU_Cmp),
    .RF_addr       (RF_addr),
    .inputReady    (inputReady),
    .ackOutput     (ackOutput),
    .readM         (readM),
    .writeM        (writeM),
    .IorD          (IorD),
    .inst_addr     (inst_addr),
    .inst_seq_addr (inst_seq_addr),
    .IRWrite       (IRWrite),
    .RegWrite      (RegWrite),
    .RegWriteSrc   (RegWriteSrc),
    .RegDst        (RegDst),
    .ALUOp         (ALUOp),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .output_active (output_active),
    .is_halted     (is_halted),
    .num_inst      (num_inst)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Serve an instruction fetch after `waits` idle cycles; counts readM and
  // IRWrite cycles. Returns at the falling edge with the FSM in ID.
  task automatic fetch(input logic [15:0] instr, input int waits,
                       output int reads, output int irw);
    reads = 0;
    irw   = 0;
    instruction = instr;
    for (int i = 0; i <= waits; i++) begin
      inputReady = (i == waits);
      #1;
      if (readM === 1'b1 && IorD === 1'b0) reads++;
      if (IRWrite === 1'b1) irw++;
      tick();
    end
    inputReady = 1'b0;
  endtask

  int reads, irw, cnt, rw;

  initial begin
    reset_n     = 1'b0;
    instruction = 16'h0000;
    ALU_out_C   = 16'h0000;
    ALU_Cmp     = 2'b00;
    RF_addr     = 16'h0000;
    inputReady  = 1'b0;
    ackOutput   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state.
    check("rst_readM", readM, 1'b0);
    check("rst_irwrite", IRWrite, 1'b0);
    check("rst_pc", inst_addr, 16'h0000);
    check("rst_num_inst", num_inst, 16'h0000);
    check("rst_halted", is_halted, 1'b0);
    check("rst_alusrca", ALUSrcA, 2'd0);

    reset_n = 1'b1;
    tick();   // INIT -> IF

    // ADI $1,$0,5 with two memory wait cycles.
    fetch(16'h4105, 2, reads, irw);
    check("adi_readM_cycles", 16'(reads), 16'd3);
    check("adi_irwrite_pulses", 16'(irw), 16'd1);
    check("adi_id_srca", ALUSrcA, 2'd2);
    check("adi_id_srcb", ALUSrcB, 2'd2);
    tick();   // EX
    check("adi_ex_srcb", ALUSrcB, 2'd2);
    check("adi_ex_aluop", ALUOp, 4'd0);
    check("adi_ex_regwrite", RegWrite, 1'b0);
    tick();   // WB
    check("adi_wb_regwrite", RegWrite, 1'b1);
    check("adi_wb_regdst", RegDst, 2'd1);
    check("adi_wb_rwsrc", RegWriteSrc, 2'd0);
    tick();   // IF
    check("adi_pc", inst_addr, 16'h0001);
    check("adi_seq", inst_seq_addr, 16'h0002);
    check("adi_num_inst", num_inst, 16'd1);

    // JMP 0x004.
    fetch(16'h9004, 0, reads, irw);
    tick();
    check("jmp_pc", inst_addr, 16'h0004);
    check("jmp_num_inst", num_inst, 16'd2);

    // BEQ $0,$0,+3 taken; target 4+1+3 = 8 presented only during ID.
    fetch(16'h1003, 0, reads, irw);
    ALU_out_C = 16'h0008;
    tick();   // EX
    ALU_out_C = 16'hDEAD;
    ALU_Cmp   = 2'b00;
    #1;
    check("beq_ex_srcb", ALUSrcB, 2'd0);
    tick();
    check("beq_taken_pc", inst_addr, 16'h0008);
    check("beq_taken_num", num_inst, 16'd3);

    fetch(16'h9004, 0, reads, irw);
    tick();
    check("jmp2_pc", inst_addr, 16'h0004);

    // Same BEQ, not taken.
    fetch(16'h1003, 0, reads, irw);
    ALU_out_C = 16'h0008;
    tick();
    ALU_Cmp = 2'b01;
    tick();
    check("beq_nt_pc", inst_addr, 16'h0005);
    check("beq_nt_num", num_inst, 16'd5);

    // BLZ +2 at PC 5, compare says less-than: target 8, zero operand.
    fetch(16'h3002, 0, reads, irw);
    ALU_out_C = 16'h0008;
    tick();
    ALU_Cmp = 2'b10;
    #1;
    check("blz_ex_srcb", ALUSrcB, 2'd3);
    tick();
    check("blz_taken_pc", inst_addr, 16'h0008);
    ALU_Cmp = 2'b00;

    // JPR to 0x2010.
    RF_addr = 16'h2010;
    fetch(16'hF019, 0, reads, irw);
    check("jpr_id_regwrite", RegWrite, 1'b0);
    tick();
    check("jpr_pc", inst_addr, 16'h2010);
    check("jpr_num", num_inst, 16'd7);

    // JAL 0x123 at 0x2010.
    fetch(16'hA123, 0, reads, irw);
    check("jal_regwrite", RegWrite, 1'b1);
    check("jal_regdst", RegDst, 2'd2);
    check("jal_rwsrc", RegWriteSrc, 2'd2);
    check("jal_seq", inst_seq_addr, 16'h2011);
    tick();
    check("jal_pc", inst_addr, 16'h2123);
    check("jal_num", num_inst, 16'd8);

    // WWD strobe for exactly the ID cycle.
    fetch(16'hF01C, 0, reads, irw);
    check("wwd_strobe_on", output_active, 1'b1);
    tick();
    check("wwd_strobe_off", output_active, 1'b0);
    check("wwd_pc", inst_addr, 16'h2124);

    // SWD with acknowledge on the fourth write cycle.
    fetch(16'h8100, 0, reads, irw);
    tick();   // EX
    check("swd_ex_srca", ALUSrcA, 2'd0);
    check("swd_ex_srcb", ALUSrcB, 2'd2);
    tick();   // MEM
    cnt = 0;
    rw  = 0;
    for (int i = 0; i < 4; i++) begin
      ackOutput = (i == 3);
      #1;
      if (writeM === 1'b1 && IorD === 1'b1) cnt++;
      if (RegWrite !== 1'b0) rw++;
      tick();
    end
    ackOutput = 1'b0;
    check("swd_writeM_cycles", 16'(cnt), 16'd4);
    check("swd_no_regwrite", 16'(rw), 16'd0);
    check("swd_writeM_drop", writeM, 1'b0);
    check("swd_pc", inst_addr, 16'h2125);
    check("swd_num", num_inst, 16'd10);

    // HLT: absorbing, no memory requests even with bus activity.
    fetch(16'hF01D, 0, reads, irw);
    tick();
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      inputReady = 1'b1;
      ackOutput  = 1'b1;
      #1;
      if (readM !== 1'b0 || writeM !== 1'b0) cnt++;
      tick();
    end
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    check("hlt_halted", is_halted, 1'b1);
    check("hlt_no_requests", 16'(cnt), 16'd0);
    check("hlt_num_frozen", num_inst, 16'd10);
    check("hlt_pc_frozen", inst_addr, 16'h2125);

    reset_n = 1'b0;
    #1;
    check("hlt_rst_halted", is_halted, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();   // INIT -> IF

    // LWD to completion, one memory wait cycle in MEM.
    fetch(16'h7100, 0, reads, irw);
    tick();   // EX
    tick();   // MEM
    cnt = 0;
    for (int i = 0; i < 2; i++) begin
      inputReady = (i == 1);
      #1;
      if (readM === 1'b1 && IorD === 1'b1) cnt++;
      tick();
    end
    inputReady = 1'b0;
    check("lwd_mem_read_cycles", 16'(cnt), 16'd2);
    check("lwd_wb_regwrite", RegWrite, 1'b1);
    check("lwd_wb_regdst", RegDst, 2'd1);
    check("lwd_wb_rwsrc", RegWriteSrc, 2'd1);
    tick();
    check("lwd_pc", inst_addr, 16'h0001);
    check("lwd_num", num_inst, 16'd1);

    // LWD interrupted by reset while waiting in MEM.
    fetch(16'h7100, 0, reads, irw);
    tick();
    tick();
    #1;
    check("lwd2_mem_readM", readM, 1'b1);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_readM_async", readM, 1'b0);
    check("midrst_writeM", writeM, 1'b0);
    check("midrst_pc", inst_addr, 16'h0000);
    check("midrst_num", num_inst, 16'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("post_rst_init_readM", readM, 1'b0);
    tick();
    #1;
    check("post_rst_if_readM", readM, 1'b1);
    check("post_rst_if_pc", inst_addr, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
